// File: rtl/elevator_ctrl_n_if.sv
// rtl/elevator_ctrl_n_if.sv - pad-side bundle between buttons/sensors, elevator controller and motor/door drivers
interface elevator_ctrl_n_if #(
    parameter int FLOORS = 4,
    parameter int FW     = $clog2(FLOORS)
);
    logic [FLOORS-1:0] floor_sns;
    logic [FLOORS-1:0] cab_req;
    logic [FLOORS-1:0] hall_up;
    logic [FLOORS-1:0] hall_dn;
    logic [1:0]        motor;
    logic [FW-1:0]     display;
    logic              door_open;
    logic [FLOORS-1:0] cab_lit;
    logic [FLOORS-1:0] up_lit;
    logic [FLOORS-1:0] dn_lit;

    modport master (
        output floor_sns, cab_req, hall_up, hall_dn,
        input  motor, display, door_open, cab_lit, up_lit, dn_lit
    );

    modport slave (
        input  floor_sns, cab_req, hall_up, hall_dn,
        output motor, display, door_open, cab_lit, up_lit, dn_lit
    );
endinterface

// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor collective-selective elevator controller with timed door
module elevator_ctrl_n #(
    parameter int FLOORS      = 4,
    parameter int FW          = $clog2(FLOORS),
    parameter int DOOR_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    elevator_ctrl_n_if.slave bus
);
    localparam int TW = $clog2(DOOR_CYCLES);
    localparam logic [TW-1:0]     T_LOAD = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] ONE    = FLOORS'(1);
    localparam logic [FLOORS-1:0] UP_OK  = ~(ONE << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_OK  = ~ONE;
    localparam logic              DIR_UP = 1'b0;
    localparam logic              DIR_DN = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

    state_t            state_q;
    logic              dir_q;
    logic [FW-1:0]     cur_q;
    logic [TW-1:0]     timer_q;
    logic [1:0]        motor_q;
    logic              door_q;
    logic [FLOORS-1:0] cab_q, up_q, dn_q;

    function automatic logic any_above(input logic [FLOORS-1:0] m, input logic [FW-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i > int'(f) && m[i]) any_above = 1'b1;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] m, input logic [FW-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i < int'(f) && m[i]) any_below = 1'b1;
    endfunction

    logic [FLOORS-1:0] pend, cur_oh, at_door;
    logic [FLOORS-1:0] cab_set, up_set, dn_set;
    logic [FLOORS-1:0] clr_cab, clr_up, clr_dn;
    logic [FW-1:0]     sns_idx, door_flr;
    logic              sns_valid, arrive, stop_up, stop_dn;
    logic              above, below, restart, enter_door;

    assign pend      = cab_q | up_q | dn_q;
    assign cur_oh    = ONE << cur_q;
    assign sns_valid = $onehot(bus.floor_sns);
    assign arrive    = sns_valid && (sns_idx != cur_q);
    assign above     = any_above(pend, cur_q);
    assign below     = any_below(pend, cur_q);

    always_comb begin
        sns_idx = '0;
        for (int i = 0; i < FLOORS; i++)
            if (bus.floor_sns[i]) sns_idx = FW'(i);
    end

    assign stop_up = cab_q[sns_idx] | up_q[sns_idx] | ~any_above(pend, sns_idx)
                   | (sns_idx == FW'(FLOORS - 1));
    assign stop_dn = cab_q[sns_idx] | dn_q[sns_idx] | ~any_below(pend, sns_idx)
                   | (sns_idx == '0);

    // Presses at the floor whose door is open only extend the dwell.
    assign at_door = (state_q == S_DOOR) ? cur_oh : '0;
    assign cab_set = bus.cab_req & ~at_door;
    assign up_set  = bus.hall_up & UP_OK & ~at_door;
    assign dn_set  = bus.hall_dn & DN_OK & ~at_door;
    assign restart = |((bus.cab_req | (bus.hall_up & UP_OK) | (bus.hall_dn & DN_OK)) & at_door);

    always_comb begin
        enter_door = 1'b0;
        door_flr   = cur_q;
        case (state_q)
            S_IDLE: enter_door = pend[cur_q];
            S_UP: begin
                enter_door = arrive && stop_up;
                door_flr   = sns_idx;
            end
            S_DOWN: begin
                enter_door = arrive && stop_dn;
                door_flr   = sns_idx;
            end
            default: ;
        endcase
    end

    // Clearing on door entry; the opposite hall call is answered only when the car will turn here.
    always_comb begin
        clr_cab = '0;
        clr_up  = '0;
        clr_dn  = '0;
        if (enter_door) begin
            clr_cab[door_flr] = 1'b1;
            if (dir_q == DIR_UP) begin
                clr_up[door_flr] = 1'b1;
                if (!any_above(pend, door_flr)) clr_dn[door_flr] = 1'b1;
            end else begin
                clr_dn[door_flr] = 1'b1;
                if (!any_below(pend, door_flr)) clr_up[door_flr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
            cur_q   <= '0;
            timer_q <= '0;
            motor_q <= 2'b00;
            door_q  <= 1'b0;
            cab_q   <= '0;
            up_q    <= '0;
            dn_q    <= '0;
        end else begin
            cab_q <= (cab_q | cab_set) & ~clr_cab;
            up_q  <= (up_q  | up_set)  & ~clr_up;
            dn_q  <= (dn_q  | dn_set)  & ~clr_dn;
            if (sns_valid) cur_q <= sns_idx;

            case (state_q)
                S_IDLE: begin
                    if (enter_door) begin
                        state_q <= S_DOOR;
                        door_q  <= 1'b1;
                        timer_q <= T_LOAD;
                    end else if (above) begin
                        state_q <= S_UP;
                        dir_q   <= DIR_UP;
                        motor_q <= 2'b01;
                    end else if (below) begin
                        state_q <= S_DOWN;
                        dir_q   <= DIR_DN;
                        motor_q <= 2'b10;
                    end
                end
                S_UP, S_DOWN: begin
                    if (enter_door) begin
                        state_q <= S_DOOR;
                        motor_q <= 2'b00;
                        door_q  <= 1'b1;
                        timer_q <= T_LOAD;
                    end
                end
                default: begin
                    if (restart) begin
                        timer_q <= T_LOAD;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        door_q <= 1'b0;
                        if ((dir_q == DIR_UP && above) || (dir_q == DIR_DN && above && !below)) begin
                            state_q <= S_UP;
                            dir_q   <= DIR_UP;
                            motor_q <= 2'b01;
                        end else if (below) begin
                            state_q <= S_DOWN;
                            dir_q   <= DIR_DN;
                            motor_q <= 2'b10;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.motor     = motor_q;
    assign bus.display   = cur_q;
    assign bus.door_open = door_q;
    assign bus.cab_lit   = cab_q;
    assign bus.up_lit    = up_q;
    assign bus.dn_lit    = dn_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb/tb_elevator_ctrl_n.sv - directed self-checking bench for elevator_ctrl_n (4 floors, 4-cycle door)
module tb_elevator_ctrl_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    elevator_ctrl_n_if #(.FLOORS(4)) bus ();

    elevator_ctrl_n #(.FLOORS(4), .DOOR_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] sns);
        rst_n = 1'b0;
        bus.floor_sns = sns;
        bus.cab_req = '0;
        bus.hall_up = '0;
        bus.hall_dn = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.floor_sns = 4'b0001;
        bus.cab_req = '0;
        bus.hall_up = '0;
        bus.hall_dn = '0;
        step();
        n_checks++; if (bus.motor !== 2'b00) begin n_fail++; $display("FAIL rst_motor: got %b want 00", bus.motor); end
        n_checks++; if (bus.display !== 2'd0) begin n_fail++; $display("FAIL rst_display: got %0d want 0", bus.display); end
        n_checks++; if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL rst_door: got %b want 0", bus.door_open); end
        n_checks++; if ({bus.cab_lit, bus.up_lit, bus.dn_lit} !== 12'h000) begin n_fail++; $display("FAIL rst_lamps: got %h want 000", {bus.cab_lit, bus.up_lit, bus.dn_lit}); end
        rst_n = 1'b1;
        step();
        step();
        n_checks++; if (bus.motor !== 2'b00 || bus.door_open !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got motor %b door %b want 00 0", bus.motor, bus.door_open); end
    endtask

    task automatic test_single_cab();
        do_reset(4'b0001);
        bus.cab_req = 4'b0100;
        step();
        bus.cab_req = 4'b0000;
        n_checks++; if (bus.cab_lit !== 4'b0100) begin n_fail++; $display("FAIL t1_latch: got %b want 0100", bus.cab_lit); end
        n_checks++; if (bus.motor !== 2'b00) begin n_fail++; $display("FAIL t1_motor_t1: got %b want 00", bus.motor); end
        step();
        n_checks++; if (bus.motor !== 2'b01) begin n_fail++; $display("FAIL t1_motor_up: got %b want 01", bus.motor); end
        bus.floor_sns = 4'b0010;
        step();
        n_checks++; if (bus.motor !== 2'b01 || bus.display !== 2'd1) begin n_fail++; $display("FAIL t1_pass1: got motor %b disp %0d want 01 1", bus.motor, bus.display); end
        bus.floor_sns = 4'b0000;
        step();
        n_checks++; if (bus.display !== 2'd1) begin n_fail++; $display("FAIL t1_between: got %0d want 1", bus.display); end
        bus.floor_sns = 4'b0100;
        step();
        n_checks++; if (bus.door_open !== 1'b1 || bus.motor !== 2'b00) begin n_fail++; $display("FAIL t1_stop: got door %b motor %b want 1 00", bus.door_open, bus.motor); end
        n_checks++; if (bus.cab_lit !== 4'b0000) begin n_fail++; $display("FAIL t1_clear: got %b want 0000", bus.cab_lit); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.door_open !== 1'b1) begin n_fail++; $display("FAIL t1_dwell%0d: got %b want 1", i, bus.door_open); end
        end
        step();
        n_checks++; if (bus.door_open !== 1'b0 || bus.motor !== 2'b00) begin n_fail++; $display("FAIL t1_close: got door %b motor %b want 0 00", bus.door_open, bus.motor); end
        step();
        n_checks++; if (bus.motor !== 2'b00 || bus.display !== 2'd2) begin n_fail++; $display("FAIL t1_idle: got motor %b disp %0d want 00 2", bus.motor, bus.display); end
    endtask

    task automatic test_hall_stop();
        do_reset(4'b0001);
        bus.hall_up = 4'b0010;
        bus.cab_req = 4'b1000;
        step();
        bus.hall_up = 4'b0000;
        bus.cab_req = 4'b0000;
        n_checks++; if (bus.up_lit !== 4'b0010 || bus.cab_lit !== 4'b1000) begin n_fail++; $display("FAIL t2_latch: got up %b cab %b want 0010 1000", bus.up_lit, bus.cab_lit); end
        step();
        bus.floor_sns = 4'b0010;
        step();
        n_checks++; if (bus.door_open !== 1'b1 || bus.up_lit !== 4'b0000) begin n_fail++; $display("FAIL t2_stop1: got door %b up %b want 1 0000", bus.door_open, bus.up_lit); end
        n_checks++; if (bus.cab_lit !== 4'b1000) begin n_fail++; $display("FAIL t2_keep3: got %b want 1000", bus.cab_lit); end
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (bus.door_open !== 1'b0 || bus.motor !== 2'b01) begin n_fail++; $display("FAIL t2_resume: got door %b motor %b want 0 01", bus.door_open, bus.motor); end
        bus.floor_sns = 4'b0100;
        step();
        n_checks++; if (bus.motor !== 2'b01 || bus.door_open !== 1'b0) begin n_fail++; $display("FAIL t2_pass2: got motor %b door %b want 01 0", bus.motor, bus.door_open); end
        bus.floor_sns = 4'b1000;
        step();
        n_checks++; if (bus.door_open !== 1'b1 || bus.cab_lit !== 4'b0000) begin n_fail++; $display("FAIL t2_stop3: got door %b cab %b want 1 0000", bus.door_open, bus.cab_lit); end
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (bus.motor !== 2'b00 || bus.door_open !== 1'b0 || bus.display !== 2'd3) begin n_fail++; $display("FAIL t2_idle: got motor %b door %b disp %0d want 00 0 3", bus.motor, bus.door_open, bus.display); end
    endtask

    task automatic test_reverse();
        do_reset(4'b0001);
        bus.hall_dn = 4'b0010;
        bus.cab_req = 4'b1000;
        step();
        bus.hall_dn = 4'b0000;
        bus.cab_req = 4'b0000;
        n_checks++; if (bus.dn_lit !== 4'b0010) begin n_fail++; $display("FAIL t3_latch: got %b want 0010", bus.dn_lit); end
        step();
        bus.floor_sns = 4'b0010;
        step();
        n_checks++; if (bus.motor !== 2'b01 || bus.door_open !== 1'b0) begin n_fail++; $display("FAIL t3_pass1: got motor %b door %b want 01 0", bus.motor, bus.door_open); end
        bus.floor_sns = 4'b0100;
        step();
        bus.floor_sns = 4'b1000;
        step();
        n_checks++; if (bus.door_open !== 1'b1 || bus.motor !== 2'b00) begin n_fail++; $display("FAIL t3_stop3: got door %b motor %b want 1 00", bus.door_open, bus.motor); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.motor !== 2'b00) begin n_fail++; $display("FAIL t3_gap%0d: got %b want 00", i, bus.motor); end
        end
        step();
        n_checks++; if (bus.motor !== 2'b10 || bus.door_open !== 1'b0) begin n_fail++; $display("FAIL t3_down: got motor %b door %b want 10 0", bus.motor, bus.door_open); end
        bus.floor_sns = 4'b0100;
        step();
        n_checks++; if (bus.motor !== 2'b10) begin n_fail++; $display("FAIL t3_pass2: got %b want 10", bus.motor); end
        bus.floor_sns = 4'b0010;
        step();
        n_checks++; if (bus.door_open !== 1'b1 || bus.dn_lit !== 4'b0000) begin n_fail++; $display("FAIL t3_stop1: got door %b dn %b want 1 0000", bus.door_open, bus.dn_lit); end
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (bus.motor !== 2'b00 || bus.door_open !== 1'b0 || bus.display !== 2'd1) begin n_fail++; $display("FAIL t3_idle: got motor %b door %b disp %0d want 00 0 1", bus.motor, bus.door_open, bus.display); end
    endtask

    task automatic test_door_restart();
        do_reset(4'b0100);
        n_checks++; if (bus.display !== 2'd2) begin n_fail++; $display("FAIL t4_pos: got %0d want 2", bus.display); end
        bus.cab_req = 4'b0100;
        step();
        bus.cab_req = 4'b0000;
        n_checks++; if (bus.cab_lit !== 4'b0100) begin n_fail++; $display("FAIL t4_latch: got %b want 0100", bus.cab_lit); end
        step();
        n_checks++; if (bus.door_open !== 1'b1 || bus.cab_lit !== 4'b0000) begin n_fail++; $display("FAIL t4_open: got door %b cab %b want 1 0000", bus.door_open, bus.cab_lit); end
        step();
        step();
        bus.cab_req = 4'b0100;
        step();
        bus.cab_req = 4'b0000;
        n_checks++; if (bus.cab_lit !== 4'b0000) begin n_fail++; $display("FAIL t4_nolatch: got %b want 0000", bus.cab_lit); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.door_open !== 1'b1) begin n_fail++; $display("FAIL t4_extend%0d: got %b want 1", i, bus.door_open); end
            step();
        end
        n_checks++; if (bus.door_open !== 1'b0 || bus.cab_lit !== 4'b0000) begin n_fail++; $display("FAIL t4_close: got door %b cab %b want 0 0000", bus.door_open, bus.cab_lit); end
    endtask

    task automatic test_multihot_ignored();
        do_reset(4'b0001);
        bus.cab_req = 4'b1000;
        step();
        bus.cab_req = 4'b0000;
        step();
        n_checks++; if (bus.motor !== 2'b01) begin n_fail++; $display("FAIL t5_go: got %b want 01", bus.motor); end
        bus.floor_sns = 4'b0110;
        bus.hall_up = 4'b1000;
        bus.hall_dn = 4'b0001;
        step();
        bus.hall_up = 4'b0000;
        bus.hall_dn = 4'b0000;
        n_checks++; if (bus.display !== 2'd0 || bus.motor !== 2'b01 || bus.door_open !== 1'b0) begin n_fail++; $display("FAIL t5_multihot: got disp %0d motor %b door %b want 0 01 0", bus.display, bus.motor, bus.door_open); end
        step();
        n_checks++; if (bus.up_lit !== 4'b0000 || bus.dn_lit !== 4'b0000) begin n_fail++; $display("FAIL t5_ignored: got up %b dn %b want 0000 0000", bus.up_lit, bus.dn_lit); end
        bus.floor_sns = 4'b0000;
        step();
        n_checks++; if (bus.motor !== 2'b01 || bus.cab_lit !== 4'b1000) begin n_fail++; $display("FAIL t5_moving: got motor %b cab %b want 01 1000", bus.motor, bus.cab_lit); end
    endtask

    task automatic test_reset_midmove();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.motor !== 2'b00 || bus.door_open !== 1'b0) begin n_fail++; $display("FAIL t6_async: got motor %b door %b want 00 0", bus.motor, bus.door_open); end
        n_checks++; if ({bus.cab_lit, bus.up_lit, bus.dn_lit} !== 12'h000) begin n_fail++; $display("FAIL t6_lamps: got %h want 000", {bus.cab_lit, bus.up_lit, bus.dn_lit}); end
        bus.floor_sns = 4'b0001;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (bus.motor !== 2'b00 || bus.door_open !== 1'b0 || bus.cab_lit !== 4'b0000) begin n_fail++; $display("FAIL t6_after: got motor %b door %b cab %b want 00 0 0000", bus.motor, bus.door_open, bus.cab_lit); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.floor_sns = 4'b0001;
        bus.cab_req = '0;
        bus.hall_up = '0;
        bus.hall_dn = '0;
        test_reset();
        test_single_cab();
        test_hall_stop();
        test_reverse();
        test_door_restart();
        test_multihot_ignored();
        test_reset_midmove();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
- Parametrised N-floor elevator controller; successor to the fixed 3-floor controller.
- Latches cab and hall (up/down) requests per floor and tracks car position from one-hot floor sensors.
- Runs a collective-selective scheduler (serve all requests in the current direction, then reverse).
- Drives motor command, floor display and a timed door; sits between the button/sensor pads and the motor/door drivers.

Parameters:
- FLOORS, 4, number of floors (2..16); floor 0 is the bottom.
- FW, $clog2(FLOORS), width of the floor index.
- DOOR_CYCLES, 8, clock cycles the door stays open (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- floor_sns  input  FLOORS  one-hot car-at-floor sensors; all-zero means between floors.
- cab_req  input  FLOORS  in-car floor buttons (pulse or level).
- hall_up  input  FLOORS  hall up buttons; bit FLOORS-1 ignored.
- hall_dn  input  FLOORS  hall down buttons; bit 0 ignored.
- motor  output  2  00 stop, 01 up, 10 down (11 never driven).
- display  output  FW  current/last floor index.
- door_open  output  1  door command.
- cab_lit, up_lit, dn_lit  output  FLOORS each  pending-request registers (button lamps).

Behaviour:
- Reset (async assert, sync release) → state IDLE, dir=UP, motor=00, display=0, door_open=0, all *_lit=0, door timer=0.
- All outputs registered.
- Request capture: pending bit sets on the clock after an input bit is sampled high, whether pulse or level.
- Ignored bits: hall_up[FLOORS-1], hall_dn[0].
- Press at the floor the door is currently open on: not latched; restarts the door timer.
- Position: cur floor updates only when floor_sns has exactly one bit set. Zero or multi-hot holds the previous value. display = cur.
- "above" / "below" = any pending bit (cab|up|dn) at a floor index >cur / <cur.
- State IDLE (motor=00, door=0), in priority order:
  - pending at cur → DOOR;
  - else above → UP, dir=UP;
  - else below → DOWN, dir=DOWN;
  - else stay.
- State UP (motor=01). On the cycle floor_sns newly reports floor f ≠ previous cur, go to DOOR if any of:
  - cab[f] or up[f];
  - nothing pending above f (then also dn[f]);
  - f == FLOORS-1.
  Otherwise keep moving.
- State DOWN (motor=10): mirror image using dn[f] and "nothing below f"; forced stop at floor 0.
- State DOOR: door_open=1, motor=00, timer loads DOOR_CYCLES-1 on entry and decrements.
  - Clear on entry: cab[cur]; hall bit in dir. Clear the opposite hall bit too if no requests remain in dir.
  - At timer=0, door_open drops the next cycle and state becomes:
    - dir=UP: above → UP; else below → DOWN (dir flips); else IDLE.
    - dir=DOWN: symmetric.
- Simultaneous set and clear of the same pending bit in one cycle: clear wins.
- motor never changes directly between 01 and 10; it always passes through ≥1 cycle of 00 (DOOR or IDLE).
- Reset mid-move or with door open: immediate return to reset values; all pending requests are lost.

Test Plan:
FLOORS=4, DOOR_CYCLES=4.
- Reset with car at floor 0, cab_req=0100 pulse at t → cab_lit=0100 at t+1, motor=01 at t+2. Stop when floor_sns=0100, door_open=1 for 4 cycles, cab_lit=0000, then IDLE, display=2.
- Car at 0; hall_up[1], cab[3] pending → stop at floor 1 (up_lit[1] cleared), continue to 3, stop, IDLE.
- Car moving up past floor 1, only hall_dn[1] and cab[3] pending → passes 1, serves 3, reverses (motor 00 ≥1 cycle then 10), serves 1, dn_lit=0000.
- Door open at floor 2, cab_req[2] pulsed at timer=1 → timer reloads, door stays open 4 more cycles, cab_lit[2] remains 0.
- floor_sns=0110 while moving up → display holds, no stop; hall_up[3] and hall_dn[0] presses → lamps stay 0.
- rst_n low while motor=01 with pending 1000 → motor=00, door_open=0, all lamps 0 asynchronously; after release, IDLE with no motion.
